// File: rtl/viterbi_pkg.sv
// Shared constants and trellis helpers for the K=3, rate-1/2 convolutional codec.
// A trellis state is {newest previous bit, oldest previous bit}.
package viterbi_pkg;
    localparam int NUM_STATES = 4;
    localparam int K = 3;
    localparam logic [K-1:0] G1 = 3'b111;
    localparam logic [K-1:0] G0 = 3'b101;
    localparam int PM_INIT = 8;

    function automatic logic [1:0] exp_sym(input logic [1:0] state, input logic b);
        logic [K-1:0] win;
        win = {b, state};
        return {^(win & G1), ^(win & G0)};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

    // Predecessor of state {b,p1} whose oldest bit is lsb.
    function automatic logic [1:0] pred_of(input logic [1:0] state, input logic lsb);
        return {state[0], lsb};
    endfunction
endpackage

// File: rtl/viterbi_codec_if.sv
// Encoder/decoder data and valid signals of the codec, grouped for port connection.
interface viterbi_codec_if;
    logic       enc_enable_i;
    logic       enc_d_in;
    logic       enc_valid_o;
    logic [1:0] enc_d_out;
    logic       dec_enable_i;
    logic [1:0] dec_d_in;
    logic       dec_valid_o;
    logic       dec_d_out;

    modport master (
        output enc_enable_i, enc_d_in, dec_enable_i, dec_d_in,
        input  enc_valid_o, enc_d_out, dec_valid_o, dec_d_out
    );
    modport slave (
        input  enc_enable_i, enc_d_in, dec_enable_i, dec_d_in,
        output enc_valid_o, enc_d_out, dec_valid_o, dec_d_out
    );
endinterface

// File: rtl/viterbi_acs_unit.sv
// Compare-select for one trellis state; ties keep the even predecessor (cand0).
module viterbi_acs_unit #(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] cand0_i,
    input  logic [PM_W-1:0] cand1_i,
    output logic [PM_W-1:0] pm_o,
    output logic            sel_o
);
    assign sel_o = (cand1_i < cand0_i);
    assign pm_o  = sel_o ? cand1_i : cand0_i;
endmodule

// File: rtl/viterbi_codec.sv
// Rate-1/2 K=3 convolutional encoder plus hard-decision register-exchange Viterbi decoder.
// The two paths share no state; only the trellis helpers in the package are common.
module viterbi_codec
    import viterbi_pkg::*;
#(
    parameter int TB_DEPTH = 32,
    parameter int PM_W     = 6
) (
    input logic           clk,
    input logic           rst,
    viterbi_codec_if.slave bus
);
    localparam int CNT_W = $clog2(TB_DEPTH);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(TB_DEPTH - 1);

    logic [1:0] sr_q;
    logic [1:0] enc_sym_q;
    logic       enc_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q        <= 2'b00;
            enc_sym_q   <= 2'b00;
            enc_valid_q <= 1'b0;
        end else if (bus.enc_enable_i) begin
            enc_sym_q   <= exp_sym({sr_q[0], sr_q[1]}, bus.enc_d_in);
            sr_q        <= {sr_q[0], bus.enc_d_in};
            enc_valid_q <= 1'b1;
        end else begin
            enc_valid_q <= 1'b0;
        end
    end

    logic [PM_W-1:0]       pm_q   [NUM_STATES];
    logic [PM_W-1:0]       pm_d   [NUM_STATES];
    logic [PM_W-1:0]       cand0  [NUM_STATES];
    logic [PM_W-1:0]       cand1  [NUM_STATES];
    logic [PM_W-1:0]       acs_pm [NUM_STATES];
    logic [NUM_STATES-1:0] acs_sel;
    logic [TB_DEPTH-1:0]   surv_q [NUM_STATES];
    logic [TB_DEPTH-1:0]   surv_d [NUM_STATES];
    logic [CNT_W-1:0]      cnt_q;
    logic [PM_W-1:0]       min_pm;
    logic [1:0]            best;
    logic                  dec_bit_q;
    logic                  dec_valid_q;

    always_comb begin
        for (int s = 0; s < NUM_STATES; s++) begin
            cand0[s] = pm_q[pred_of(2'(s), 1'b0)]
                     + PM_W'(hamming2(bus.dec_d_in, exp_sym(pred_of(2'(s), 1'b0), s >= 2)));
            cand1[s] = pm_q[pred_of(2'(s), 1'b1)]
                     + PM_W'(hamming2(bus.dec_d_in, exp_sym(pred_of(2'(s), 1'b1), s >= 2)));
        end
    end

    for (genvar g = 0; g < NUM_STATES; g++) begin : g_acs
        viterbi_acs_unit #(.PM_W(PM_W)) u_acs (
            .cand0_i (cand0[g]),
            .cand1_i (cand1[g]),
            .pm_o    (acs_pm[g]),
            .sel_o   (acs_sel[g])
        );
    end

    // Strict compare picks the lowest-index state among equal minima.
    always_comb begin
        min_pm = acs_pm[0];
        best   = 2'd0;
        for (int s = 1; s < NUM_STATES; s++) begin
            if (acs_pm[s] < min_pm) begin
                min_pm = acs_pm[s];
                best   = 2'(s);
            end
        end
        for (int s = 0; s < NUM_STATES; s++) begin
            pm_d[s]   = acs_pm[s] - min_pm;
            surv_d[s] = {surv_q[pred_of(2'(s), acs_sel[s])][TB_DEPTH-2:0], s >= 2};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NUM_STATES; s++) begin
                pm_q[s]   <= (s == 0) ? '0 : PM_W'(PM_INIT);
                surv_q[s] <= '0;
            end
            cnt_q       <= '0;
            dec_bit_q   <= 1'b0;
            dec_valid_q <= 1'b0;
        end else if (bus.dec_enable_i) begin
            pm_q        <= pm_d;
            surv_q      <= surv_d;
            if (cnt_q != CNT_SAT)
                cnt_q <= cnt_q + CNT_W'(1);
            dec_bit_q   <= surv_d[best][TB_DEPTH-1];
            dec_valid_q <= (cnt_q == CNT_SAT);
        end else begin
            dec_valid_q <= 1'b0;
        end
    end

    assign bus.enc_valid_o = enc_valid_q;
    assign bus.enc_d_out   = enc_sym_q;
    assign bus.dec_valid_o = dec_valid_q;
    assign bus.dec_d_out   = dec_bit_q;
endmodule

// File: tb/tb_viterbi_codec.sv
// Loopback bench for viterbi_codec: reference encoder from the generator equations and
// expected decoder output as the information stream delayed by TB_DEPTH-1 symbols.
module tb_viterbi_codec;
    localparam int D = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    viterbi_codec_if bus ();
    viterbi_codec #(.TB_DEPTH(D), .PM_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        bus.enc_enable_i = 1'b0;
        bus.enc_d_in     = 1'b0;
        bus.dec_enable_i = 1'b0;
        bus.dec_d_in     = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_enc_valid", bus.enc_valid_o, 0);
        chk("rst_enc_out", bus.enc_d_out, 0);
        chk("rst_dec_valid", bus.dec_valid_o, 0);
        chk("rst_dec_out", bus.dec_d_out, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // mode 0 clean, 1 flip c0 every 16th symbol below 256, 2 burst on symbols 150..152.
    // abort_at > 0 stops right after that many symbols reached the decoder.
    task automatic run_stream(input string name, input int nbits, input int duty,
                              input int mode, input int abort_at, output int errs);
        bit         info[$];
        int         total, sent, fed, cyc, late, n, budget;
        logic       p1, p2, d, exp_v, fed_last, exp_dec;
        logic [1:0] exp_s, m;
        total = nbits + D - 1;
        budget = total * 4 + 200;
        sent = 0; fed = 0; cyc = 0; late = 0; errs = 0;
        p1 = 1'b0; p2 = 1'b0; exp_v = 1'b0; fed_last = 1'b0; exp_dec = 1'b0;
        exp_s = 2'b00;
        while (fed < total || fed_last) begin
            if (cyc >= budget) begin
                compared++;
                mismatched++;
                $error("FAIL %s_timeout observed=%0d expected<%0d", name, cyc, budget);
                break;
            end
            cyc++;
            @(negedge clk);
            chk({name, "_enc_valid"}, bus.enc_valid_o, exp_v);
            chk({name, "_enc_out"}, bus.enc_d_out, exp_s);
            if (fed_last) begin
                n = fed - 1;
                chk({name, "_dec_valid"}, bus.dec_valid_o, n >= D - 1);
                exp_dec = (n >= D - 1) ? info[n - (D - 1)] : 1'b0;
                if (bus.dec_d_out !== exp_dec) begin
                    errs++;
                    if (n - (D - 1) >= 200) late++;
                end
                if (mode != 2) chk({name, "_dec_bit"}, bus.dec_d_out, exp_dec);
            end else begin
                chk({name, "_idle_dec_valid"}, bus.dec_valid_o, 0);
                if (mode != 2) chk({name, "_idle_dec_hold"}, bus.dec_d_out, exp_dec);
            end
            if (abort_at > 0 && fed == abort_at) break;
            if (exp_v) begin
                m = 2'b00;
                if (mode == 1 && fed < 256 && fed % 16 == 0) m = 2'b01;
                if (mode == 2 && fed >= 150 && fed <= 152) m = 2'b11;
                bus.dec_enable_i = 1'b1;
                bus.dec_d_in     = bus.enc_d_out ^ m;
                fed++;
                fed_last = 1'b1;
            end else begin
                bus.dec_enable_i = 1'b0;
                fed_last = 1'b0;
            end
            if (sent < total && $urandom_range(99) < duty) begin
                d = (sent < nbits) ? 1'($urandom_range(1)) : 1'b0;
                info.push_back(d);
                bus.enc_enable_i = 1'b1;
                bus.enc_d_in     = d;
                exp_s = {d ^ p1 ^ p2, d ^ p2};
                p2 = p1;
                p1 = d;
                exp_v = 1'b1;
                sent++;
            end else begin
                bus.enc_enable_i = 1'b0;
                exp_v = 1'b0;
            end
        end
        bus.enc_enable_i = 1'b0;
        bus.dec_enable_i = 1'b0;
        if (mode == 2) begin
            $display("burst stream: %0d decoded bit errors, %0d after bit 200", errs, late);
            chk({name, "_burst_bounded"}, errs <= 12, 1);
            chk({name, "_burst_late_errs"}, late, 0);
        end
    endtask

    initial begin
        logic       vec_bits [5];
        logic [1:0] vec_syms [5];
        int         e;
        vec_bits = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        vec_syms = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01};

        do_reset();
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("vec_valid", bus.enc_valid_o, 1);
                chk("vec_sym", bus.enc_d_out, vec_syms[i-1]);
            end
            bus.enc_enable_i = (i < 5);
            bus.enc_d_in     = (i < 5) ? vec_bits[i] : 1'b0;
        end
        @(negedge clk);
        chk("vec_idle_valid", bus.enc_valid_o, 0);
        chk("vec_idle_hold", bus.enc_d_out, 2'b01);

        do_reset();
        run_stream("clean", 300, 100, 0, 0, e);
        do_reset();
        run_stream("periodic", 300, 100, 1, 0, e);
        do_reset();
        run_stream("gapped", 300, 50, 0, 0, e);
        do_reset();
        run_stream("burst", 300, 100, 2, 0, e);

        do_reset();
        run_stream("pre_reset", 300, 100, 0, 100, e);
        rst = 1'b0;
        #1;
        chk("mid_rst_enc_valid", bus.enc_valid_o, 0);
        chk("mid_rst_enc_out", bus.enc_d_out, 0);
        chk("mid_rst_dec_valid", bus.dec_valid_o, 0);
        chk("mid_rst_dec_out", bus.dec_d_out, 0);
        @(negedge clk);
        rst = 1'b1;
        run_stream("post_reset", 100, 100, 0, 0, e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/viterbi_codec.md
Name: viterbi_codec

Overview:
- Rate-1/2, constraint-length-3 convolutional encoder and hard-decision Viterbi decoder, packaged as one block.
- The two paths are independent. The channel model outside the block (register stage plus bit-error injection) connects enc_d_out / enc_valid_o to dec_d_in / dec_enable_i.
- Generators are g1=111 (octal 7) and g0=101 (octal 5). The decoder uses register-exchange survivor storage.

Parameters:
- TB_DEPTH, 32: survivor path length in symbols; sets decoder latency. Legal range 8..64.
- PM_W, 6: path-metric width in bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- enc_enable_i  in  1  encoder input bit valid this cycle.
- enc_d_in  in  1  information bit.
- enc_valid_o  out  1  enc_d_out valid.
- enc_d_out  out  2  code symbol {c1,c0}.
- dec_enable_i  in  1  dec_d_in valid this cycle.
- dec_d_in  in  2  received hard symbol {c1,c0}, possibly corrupted.
- dec_valid_o  out  1  dec_d_out valid.
- dec_d_out  out  1  decoded bit.

Behaviour:
- Reset (async, rst=0): encoder shift register sr[1:0]=0, enc_d_out=0, enc_valid_o=0.
- Reset also clears: decoder path metrics (PM[0]=0, PM[1..3]=8), all survivors=0, symbol counter=0, dec_d_out=0, dec_valid_o=0.
- Encoder, on a clock edge with enc_enable_i=1:
  - enc_d_out[1] <= d^sr[0]^sr[1]; enc_d_out[0] <= d^sr[1].
  - sr <= {sr[0], d}; sr[0] is the newest previous bit.
  - enc_valid_o <= 1.
- Encoder, with enc_enable_i=0: enc_valid_o <= 0; sr and enc_d_out hold.
- Encoder latency is 1 clock. Back-to-back enables are sustained every cycle.
- Decoder state s = {sr[0],sr[1]} (2 bits, 4 states). Input bit b moves state {p1,p2} to {b,p1}. The predecessors of {b,p1} are {p1,0} and {p1,1}.
- Branch metric: Hamming distance (0..2) between dec_d_in and the expected symbol for (predecessor, b).
- ACS: candidate = PM[pred]+BM. Keep the smaller candidate; on a tie keep the predecessor whose LSB is 0.
- Normalization: after ACS, subtract the minimum new metric from all four metrics every step. PM_W must never overflow.
- Survivors: new_surv[s] = {surv[chosen_pred][TB_DEPTH-2:0], b}, where b = s[1].
- Output, on an edge with dec_enable_i=1 consuming symbol n (n counted from 0 after reset):
  - dec_d_out <= new_surv[best][TB_DEPTH-1], where best is the lowest-index state with minimum new metric.
  - This output is the decision for information bit n-(TB_DEPTH-1).
  - dec_valid_o <= (n >= TB_DEPTH-1).
- Decoder, with dec_enable_i=0: all decoder state holds and dec_valid_o <= 0.
- Symbol counter saturates once it reaches TB_DEPTH-1.
- No tail flushing. The final TB_DEPTH-1 bits emerge only if the user feeds further symbols (e.g. zero-input tail).
- Error-free stream: dec_d_out reproduces enc_d_in exactly, delayed TB_DEPTH-1 enabled symbols.
- Error correction: any isolated symbol error corrects with zero residual bit errors when errors are spaced ≥8 symbols apart (free distance 5).
- Reset mid-stream aborts immediately. Decoding restarts from state 0, with no valid output for TB_DEPTH-1 symbols.

Decomposition:
- Package viterbi_pkg contains:
  - NUM_STATES=4 and K=3.
  - Generator constants G1=3'b111, G0=3'b101.
  - Function exp_sym(state, bit) returning the 2-bit expected symbol, shared by encoder and branch-metric logic.
  - Init metric constant PM_INIT=8.
- One sub-module, viterbi_acs_unit: one state's ACS (two candidate metrics in, chosen metric and select bit out). Instantiate it 4 times.
- The encoder path is small and stays inline.

Test Plan:
- Encoder vector: after reset, enc_d_in=1,0,1,1,0 on consecutive enabled cycles -> enc_d_out=11,10,00,01,01, each one clock later, with enc_valid_o=1.
- Clean loopback: encoder output registered one stage into the decoder, 300 random bits, TB_DEPTH=32 -> dec_d_out matches input delayed 31 symbols; dec_valid_o first rises on symbol 31.
- Periodic error: flip dec_d_in[0] on every 16th symbol for the first 256 symbols -> zero decoded bit errors.
- Gapped enables: random enable duty ~50% on both paths -> no state change on idle cycles; same decoded sequence as the continuous case.
- Burst error: flip both bits of 3 consecutive symbols once -> at most a small local error burst, then a clean resumption (report count).
- Reset mid-stream at symbol 100 -> all outputs 0 immediately; after re-start the first valid output appears on symbol 31 and is correct.
